// File: rtl/apb_interface_2.sv
// APB slave bridging a byte-wide register file to an OOK RF front end: serial TX shifter and pulse-window RX demodulator.
// APB has zero wait states (PREADY tied high); the RX register is refilled by CMD start, one packet byte per command.
module apb_interface_2 #(
    parameter int BIT_CYCLES = 10000,
    parameter int PULSE_POS  = 5000,
    parameter int PRE_LEN    = 8,
    parameter int PKT_BITS   = 64
) (
    input  logic        i_PCLK,
    input  logic        i_PRESET,
    input  logic        i_PSEL0,
    input  logic        i_PENABLE,
    input  logic        i_PWRITE,
    input  logic [15:0] i_PADDR,
    input  logic [7:0]  i_PWDATA,
    input  logic [7:0]  i_PRDATA,
    input  logic [9:0]  i_BASE_ADDR,
    output logic        o_WR0,
    output logic        o_WR1,
    output logic        o_WR2,
    output logic        o_WR3,
    output logic        o_DR0,
    output logic        o_DR1,
    output logic        o_DR2,
    output logic        o_DR3,
    output logic        PREADY,
    output logic [7:0]  o_PWDATA,
    output logic [7:0]  o_PRDATA,
    input  logic        rfin,
    input  logic        RX,
    output logic        pkt_rec,
    output logic        TX_OUT,
    output logic        sh_en
);

    localparam int TW = $clog2(BIT_CYCLES);
    localparam int PW = $clog2(PRE_LEN + 1);
    localparam int BW = $clog2(PKT_BITS + 1);
    localparam logic [TW-1:0] T_LAST  = TW'(BIT_CYCLES - 1);
    localparam logic [TW-1:0] T_PULSE = TW'(PULSE_POS);
    localparam logic [PW-1:0] PRE_FULL = PW'(PRE_LEN);
    localparam logic [BW-1:0] PKT_LAST = BW'(PKT_BITS - 1);

    localparam logic [5:0] OFF_CFG = 6'h00;
    localparam logic [5:0] OFF_TX  = 6'h04;
    localparam logic [5:0] OFF_CMD = 6'h0C;

    localparam logic [1:0] HUNT = 2'd0;
    localparam logic [1:0] PRE  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [5:0] cfg;
    logic [7:0] tx_reg;
    logic [7:0] rx_reg;
    logic       hit, wr, start;
    logic [5:0] offs;
    logic [7:0] status;

    logic          tx_busy;
    logic [7:0]    tx_shift;
    logic [TW-1:0] tx_timer;
    logic [2:0]    tx_bit;

    logic                rf_s1, rf_s2, rf_s3, rf_edge;
    logic [1:0]          rx_state;
    logic [TW-1:0]       rx_timer;
    logic                rx_seen;
    logic [PW-1:0]       pre_cnt;
    logic [BW-1:0]       bit_cnt;
    logic [PKT_BITS-1:0] rx_shift, rx_next, pkt_reg;
    logic [2:0]          rx_idx;

    logic unused_bits;
    assign unused_bits = ^{i_PRDATA, cfg[5:4], cfg[1:0]};

    assign hit    = i_PSEL0 && (i_PADDR[15:6] == i_BASE_ADDR);
    assign offs   = i_PADDR[5:0];
    assign wr     = hit && i_PENABLE && i_PWRITE;
    assign start  = wr && (offs == OFF_CMD) && i_PWDATA[1];
    assign status = {2'b00, rx_idx, RX, pkt_rec, tx_busy};
    assign PREADY = 1'b1;

    always_comb begin
        o_PRDATA = '0;
        if (hit && !i_PWRITE) begin
            case (offs)
                OFF_CFG: o_PRDATA = status;
                OFF_TX:  o_PRDATA = rx_reg;
                default: o_PRDATA = '0;
            endcase
        end
    end

    assign o_WR0 = tx_busy && (cfg[3:2] == 2'd0);
    assign o_WR1 = tx_busy && (cfg[3:2] == 2'd1);
    assign o_WR2 = tx_busy && (cfg[3:2] == 2'd2);
    assign o_WR3 = tx_busy && (cfg[3:2] == 2'd3);
    assign o_DR0 = pkt_rec && (cfg[3:2] == 2'd0);
    assign o_DR1 = pkt_rec && (cfg[3:2] == 2'd1);
    assign o_DR2 = pkt_rec && (cfg[3:2] == 2'd2);
    assign o_DR3 = pkt_rec && (cfg[3:2] == 2'd3);

    always_ff @(posedge i_PCLK) begin
        if (i_PRESET) begin
            cfg      <= '0;
            tx_reg   <= '0;
            o_PWDATA <= '0;
        end else if (wr) begin
            o_PWDATA <= i_PWDATA;
            if (offs == OFF_CFG) cfg    <= i_PWDATA[5:0];
            if (offs == OFF_TX)  tx_reg <= i_PWDATA;
        end
    end

    // TX_OUT and sh_en change on the same edge that begins each bit period.
    always_ff @(posedge i_PCLK) begin
        if (i_PRESET) begin
            tx_busy  <= 1'b0;
            tx_shift <= '0;
            tx_timer <= '0;
            tx_bit   <= '0;
            TX_OUT   <= 1'b0;
            sh_en    <= 1'b0;
        end else begin
            sh_en <= 1'b0;
            if (start && !RX && !tx_busy) begin
                tx_busy  <= 1'b1;
                tx_shift <= tx_reg;
                TX_OUT   <= tx_reg[7];
                sh_en    <= 1'b1;
                tx_timer <= '0;
                tx_bit   <= '0;
            end else if (tx_busy) begin
                if (tx_timer == T_LAST) begin
                    tx_timer <= '0;
                    if (tx_bit == 3'd7) begin
                        tx_busy <= 1'b0;
                        TX_OUT  <= 1'b0;
                    end else begin
                        tx_bit   <= tx_bit + 1'b1;
                        tx_shift <= tx_shift << 1;
                        TX_OUT   <= tx_shift[6];
                        sh_en    <= 1'b1;
                    end
                end else begin
                    tx_timer <= tx_timer + 1'b1;
                end
            end
        end
    end

    assign rf_edge = rf_s2 && !rf_s3;
    assign rx_next = (rx_shift << 1) | {{(PKT_BITS-1){1'b0}}, rx_seen};

    // Every edge re-centres the bit timer on the pulse, so a window closes half a bit after the last pulse.
    always_ff @(posedge i_PCLK) begin
        if (i_PRESET) begin
            rf_s1    <= 1'b0;
            rf_s2    <= 1'b0;
            rf_s3    <= 1'b0;
            rx_state <= HUNT;
            rx_timer <= '0;
            rx_seen  <= 1'b0;
            pre_cnt  <= '0;
            bit_cnt  <= '0;
            rx_shift <= '0;
            pkt_reg  <= '0;
            pkt_rec  <= 1'b0;
            rx_idx   <= '0;
            rx_reg   <= '0;
        end else begin
            rf_s1 <= rfin;
            rf_s2 <= rf_s1;
            rf_s3 <= rf_s2;

            // Bytes leave MSB first: the next unread byte is always at the top of pkt_reg.
            if (start && RX) begin
                if (pkt_rec) begin
                    rx_reg  <= pkt_reg[PKT_BITS-1 -: 8];
                    pkt_reg <= pkt_reg << 8;
                    if (rx_idx == 3'd7) begin
                        pkt_rec <= 1'b0;
                        rx_idx  <= '0;
                    end else begin
                        rx_idx <= rx_idx + 1'b1;
                    end
                end else begin
                    rx_reg <= '0;
                end
            end

            if (!RX) begin
                rx_state <= HUNT;
            end else begin
                case (rx_state)
                    HUNT: begin
                        if (rf_edge) begin
                            rx_state <= PRE;
                            rx_timer <= T_PULSE;
                            rx_seen  <= 1'b1;
                            pre_cnt  <= PW'(1);
                        end
                    end
                    PRE, DATA: begin
                        if (rf_edge) begin
                            rx_timer <= T_PULSE;
                            rx_seen  <= 1'b1;
                            if (rx_state == PRE && !rx_seen) pre_cnt <= pre_cnt + 1'b1;
                        end else if (rx_timer == T_LAST) begin
                            rx_timer <= '0;
                            rx_seen  <= 1'b0;
                            if (rx_state == PRE) begin
                                if (!rx_seen) begin
                                    rx_state <= HUNT;
                                end else if (pre_cnt == PRE_FULL) begin
                                    rx_state <= DATA;
                                    bit_cnt  <= '0;
                                end
                            end else begin
                                rx_shift <= rx_next;
                                bit_cnt  <= bit_cnt + 1'b1;
                                if (bit_cnt == PKT_LAST) begin
                                    pkt_reg  <= rx_next;
                                    pkt_rec  <= 1'b1;
                                    rx_idx   <= '0;
                                    rx_state <= HUNT;
                                end
                            end
                        end else begin
                            rx_timer <= rx_timer + 1'b1;
                        end
                    end
                    default: rx_state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apb_interface_2.sv
// Bench for apb_interface_2 with shortened bit periods; TX, RX and reset behaviour compared against a small model.
`timescale 1ns/1ps
module tb_apb_interface_2;

    localparam int BC = 100;
    localparam int PP = 50;
    localparam logic [31:0] EXP_RST = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [7:0]  pwdata;
    logic        wr0, wr1, wr2, wr3, dr0, dr1, dr2, dr3, pready;
    logic [7:0]  pwdata_o, prdata_o;
    logic        rfin, rx_mode, pkt_rec, tx_out, sh_en;

    int   errors = 0;
    int   checks = 0;
    logic m_pkt = 1'b0;
    int   m_idx = 0;
    logic [63:0] pkt_a = 64'h8123456789ABCD0F;

    always #5 clk = ~clk;

    apb_interface_2 #(.BIT_CYCLES(BC), .PULSE_POS(PP), .PRE_LEN(8), .PKT_BITS(64)) dut (
        .i_PCLK(clk), .i_PRESET(rst), .i_PSEL0(psel), .i_PENABLE(penable), .i_PWRITE(pwrite),
        .i_PADDR(paddr), .i_PWDATA(pwdata), .i_PRDATA(8'h00), .i_BASE_ADDR(10'h001),
        .o_WR0(wr0), .o_WR1(wr1), .o_WR2(wr2), .o_WR3(wr3),
        .o_DR0(dr0), .o_DR1(dr1), .o_DR2(dr2), .o_DR3(dr3),
        .PREADY(pready), .o_PWDATA(pwdata_o), .o_PRDATA(prdata_o),
        .rfin(rfin), .RX(rx_mode), .pkt_rec(pkt_rec), .TX_OUT(tx_out), .sh_en(sh_en)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {4'h0, wr3, wr2, wr1, wr0, dr3, dr2, dr1, dr0,
                pkt_rec, tx_out, sh_en, pready, pwdata_o, prdata_o};
    endfunction

    function automatic logic [7:0] status_exp(input logic busy);
        return {2'b00, 3'(m_idx), rx_mode, m_pkt, busy};
    endfunction

    task automatic apb_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1 d = prdata_o;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 check_eq(tag, outs(), EXP_RST);
        m_pkt = 1'b0;
        m_idx = 0;
    endtask

    // Pulses sit on a nominal bit grid, each displaced by up to +/-jit clocks.
    task automatic send_frame(input logic [63:0] p, input int npre, input int ndat, input int jit);
        int t, n, pos;
        logic one;
        t = 0;
        n = npre + ndat;
        for (int k = 0; k < n; k++) begin
            one = (k < npre) ? 1'b1 : p[63 - (k - npre)];
            pos = k * BC + PP;
            if (jit > 0) pos = pos + int'($urandom_range(2 * jit)) - jit;
            if (one) begin
                while (t < pos) begin @(posedge clk); t++; end
                #3 rfin = 1'b1;
                repeat (10) begin @(posedge clk); t++; end
                #3 rfin = 1'b0;
            end
        end
        while (t < n * BC + BC) begin @(posedge clk); t++; end
        @(negedge clk);
    endtask

    task automatic rx_frame(input logic [63:0] p, input int jit, input string tag);
        logic [7:0] d;
        send_frame(p, 8, 64, jit);
        m_pkt = 1'b1;
        m_idx = 0;
        check_eq({tag, "_pkt_rec"}, pkt_rec, m_pkt);
        apb_read(16'h0040, d);
        check_eq({tag, "_status"}, d, status_exp(1'b0));
        for (int i = 0; i < 8; i++) begin
            apb_write(16'h004C, 8'h02);
            apb_read(16'h0044, d);
            check_eq($sformatf("%s_byte%0d", tag, i), d, p[63 - 8 * i -: 8]);
            m_idx++;
            if (m_idx == 8) begin
                m_idx = 0;
                m_pkt = 1'b0;
            end
            check_eq($sformatf("%s_dr_%0d", tag, i), {pkt_rec, dr3, dr2, dr1, dr0}, {m_pkt, m_pkt, 3'b000});
        end
        apb_read(16'h0040, d);
        check_eq({tag, "_status_end"}, d, status_exp(1'b0));
    endtask

    // Starts at the falling edge right after the CMD commit; holds a STATUS read for the whole transfer.
    task automatic tx_check(input logic [7:0] b);
        int pulses, gap_err, bit_err, stat_err, wr_err;
        logic [7:0] got;
        logic busy;
        pulses = 0; gap_err = 0; bit_err = 0; stat_err = 0; wr_err = 0; got = '0;
        psel = 1'b1; pwrite = 1'b0; paddr = 16'h0040; penable = 1'b1;
        for (int k = 0; k < 9 * BC; k++) begin
            #1;
            busy = (k < 8 * BC);
            if (sh_en) begin
                if (k % BC != 0) gap_err++;
                got = {got[6:0], tx_out};
                pulses++;
            end
            if (tx_out !== (busy ? b[7 - k / BC] : 1'b0)) bit_err++;
            if (prdata_o !== status_exp(busy)) stat_err++;
            if ({wr3, wr2, wr1, wr0} !== {busy, 3'b000}) wr_err++;
            @(negedge clk);
        end
        psel = 1'b0; penable = 1'b0;
        check_eq("tx_pulses", pulses, 8);
        check_eq("tx_pulse_spacing", gap_err, 0);
        check_eq("tx_bits", got, b);
        check_eq("tx_out_trace", bit_err, 0);
        check_eq("tx_status_busy", stat_err, 0);
        check_eq("tx_wr_flags", wr_err, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  d;
        logic [63:0] p;
        int          cnt;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; rfin = 1'b0; rx_mode = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 check_eq("reset_outs", outs(), EXP_RST);

        apb_write(16'h0040, 8'h0F);
        check_eq("pwdata_cfg", pwdata_o, 8'h0F);
        apb_read(16'h0040, d);
        check_eq("status_idle", d, status_exp(1'b0));
        apb_write(16'h0048, 8'h5A);
        check_eq("pwdata_unmapped", pwdata_o, 8'h5A);
        apb_read(16'h0048, d);
        check_eq("read_unmapped", d, 8'h00);
        apb_write(16'h0080, 8'h00);
        check_eq("pwdata_other_base", pwdata_o, 8'h5A);

        apb_write(16'h0044, 8'hA5);
        apb_write(16'h004C, 8'h02);
        tx_check(8'hA5);

        apb_write(16'h004C, 8'h02);
        repeat (250) @(negedge clk);
        check_eq("tx_mid_bit", tx_out, 8'hA5 >> (7 - 250 / BC) & 8'h01);
        reset_pulse("reset_during_tx");
        cnt = 0;
        repeat (9 * BC) begin
            @(negedge clk);
            if (sh_en || tx_out || wr0) cnt++;
        end
        check_eq("tx_after_reset", cnt, 0);

        apb_write(16'h0040, 8'h0F);
        rx_mode = 1'b1;
        rx_frame(pkt_a, 0, "rx_nom");
        rx_frame(pkt_a, 10, "rx_jit");

        apb_write(16'h004C, 8'h02);
        apb_read(16'h0044, d);
        check_eq("rx_load_empty", d, 8'h00);
        apb_read(16'h0040, d);
        check_eq("status_empty", d, status_exp(1'b0));

        p = {$urandom, $urandom};
        send_frame(p, 4, 0, 0);
        repeat (200) @(negedge clk);
        check_eq("broken_preamble", pkt_rec, 1'b0);
        rx_frame({$urandom, $urandom}, 10, "rx_after_broken");

        send_frame(pkt_a, 8, 64, 0);
        check_eq("unread_pkt_rec", pkt_rec, 1'b1);
        send_frame(p, 8, 20, 0);
        reset_pulse("reset_during_data");
        apb_write(16'h0040, 8'h0F);
        rx_frame({$urandom, $urandom}, 10, "rx_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
